// File: rtl/grf_writeback_if.sv
// grf_writeback_if: bundle between the MEM stage / decode (master) and the
// write-back block that owns the general register file (slave).
//   mem_*          MEM/WB pipeline register inputs
//   GRF_addr_k     decode read addresses, GRF_data_k combinational read data
//   wb_*           retiring instruction, for hazard / forwarding and trace
//   retired_count  number of valid instructions that passed WB
interface grf_writeback_if;
  logic        mem_valid;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_wsel;
  logic [31:0] mem_alu;
  logic [31:0] mem_dm;
  logic [31:0] mem_do;
  logic [31:0] mem_pc;

  logic [4:0]  GRF_addr_1;
  logic [4:0]  GRF_addr_2;
  logic [31:0] GRF_data_1;
  logic [31:0] GRF_data_2;

  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic [31:0] retired_count;

  modport master (
    output mem_valid, mem_waddr, mem_wsel, mem_alu, mem_dm, mem_do, mem_pc,
    output GRF_addr_1, GRF_addr_2,
    input  GRF_data_1, GRF_data_2,
    input  wb_valid, wb_waddr, wb_wdata, wb_pc, retired_count
  );

  modport slave (
    input  mem_valid, mem_waddr, mem_wsel, mem_alu, mem_dm, mem_do, mem_pc,
    input  GRF_addr_1, GRF_addr_2,
    output GRF_data_1, GRF_data_2,
    output wb_valid, wb_waddr, wb_wdata, wb_pc, retired_count
  );
endinterface

// File: rtl/grf_writeback.sv
// grf_writeback: MEM/WB pipeline register, write-back select, 32x32 GRF and
// decode's two combinational read ports with write-back bypass.
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears WB register, GRF and counter
//   bus    grf_writeback_if.slave (MEM inputs, read ports, WB outputs)

// One decode read port: $0 reads zero, the retiring write bypasses the
// array so decode sees it in the same cycle, otherwise the array entry.
module grf_read_port #(
  parameter int REG_COUNT = 32
) (
  input  logic [4:0]                  addr,
  input  logic                        we,
  input  logic [4:0]                  waddr,
  input  logic [31:0]                 wdata,
  input  logic [REG_COUNT-1:0][31:0]  rf,
  output logic [31:0]                 data
);
  always_comb begin
    data = '0;
    if (addr == 5'd0)                  data = '0;
    else if (we && addr == waddr)      data = wdata;
    else if (32'(addr) < REG_COUNT)    data = rf[addr];
  end
endmodule

module grf_writeback #(
  parameter int          REG_COUNT   = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  grf_writeback_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic        vld;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] dov;
    logic [31:0] pc;
  } wb_reg_t;

  wb_reg_t                        wb_q;
  logic [31:0]                    wdata;
  logic                           we;
  logic [REG_COUNT-1:0][31:0]     rf_q;
  logic [31:0]                    retired_q;
  logic [NUM_PORTS-1:0][4:0]      rd_addr;
  logic [NUM_PORTS-1:0][31:0]     rd_data;

  // MEM/WB register: no stall, captures every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q.vld   <= bus.mem_valid;
      wb_q.waddr <= bus.mem_waddr;
      wb_q.wsel  <= bus.mem_wsel;
      wb_q.alu   <= bus.mem_alu;
      wb_q.dm    <= bus.mem_dm;
      wb_q.dov   <= bus.mem_do;
      wb_q.pc    <= bus.mem_pc;
    end
  end

  always_comb begin
    wdata = '0;
    case (wb_q.wsel)
      2'd0:    wdata = wb_q.alu;
      2'd1:    wdata = wb_q.dm;
      2'd2:    wdata = wb_q.dov;
      default: wdata = '0;
    endcase
  end

  // $0 writes and wsel 3 retire without touching the array.
  assign we = wb_q.vld && (wb_q.wsel != 2'd3) && (wb_q.waddr != 5'd0);

  // Entry 0 is held at zero and never written (we excludes waddr 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++)
        rf_q[r] <= (r == 0) ? 32'h0 : RESET_VALUE;
    end else if (we && 32'(wb_q.waddr) < REG_COUNT) begin
      rf_q[wb_q.waddr] <= wdata;
    end
  end

  // Counts every valid retirement, including ones that do not write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         retired_q <= '0;
    else if (wb_q.vld)  retired_q <= retired_q + 32'd1;
  end

  assign rd_addr = {bus.GRF_addr_2, bus.GRF_addr_1};

  grf_read_port #(.REG_COUNT(REG_COUNT)) u_rd [NUM_PORTS-1:0] (
    .addr  (rd_addr),
    .we    (we),
    .waddr (wb_q.waddr),
    .wdata (wdata),
    .rf    (rf_q),
    .data  (rd_data)
  );

  assign bus.GRF_data_1    = rd_data[0];
  assign bus.GRF_data_2    = rd_data[1];
  assign bus.wb_valid      = we;
  assign bus.wb_waddr      = we ? wb_q.waddr : 5'd0;
  assign bus.wb_wdata      = wdata;
  assign bus.wb_pc         = wb_q.pc;
  assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_grf_writeback.sv
module tb_grf_writeback;
  localparam logic [31:0] RV = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_writeback_if bus();

  grf_writeback #(.REG_COUNT(32), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        vld;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [31:0] alu, dm, dov, pc;
  } wb_t;

  logic [31:0] m_reg [32];
  wb_t         m_pend;
  logic [31:0] m_cnt;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] m_wdata();
    case (m_pend.wsel)
      2'd0:    return m_pend.alu;
      2'd1:    return m_pend.dm;
      2'd2:    return m_pend.dov;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_we();
    return m_pend.vld && m_pend.wsel != 2'd3 && m_pend.waddr != 5'd0;
  endfunction

  // Decode sees the register file as if the retiring write were already done.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] view [32];
    view = m_reg;
    if (m_we()) view[m_pend.waddr] = m_wdata();
    return (a == 5'd0) ? 32'h0 : view[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = (i == 0) ? 32'h0 : RV;
    m_pend = '{1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    m_cnt  = 32'h0;
  endtask

  task automatic m_edge();
    if (m_we()) m_reg[m_pend.waddr] = m_wdata();
    if (m_pend.vld) m_cnt = m_cnt + 32'd1;
    m_pend = '{bus.mem_valid, bus.mem_waddr, bus.mem_wsel,
               bus.mem_alu, bus.mem_dm, bus.mem_do, bus.mem_pc};
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] wa, input logic [1:0] ws,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] dv, input logic [31:0] pc);
    bus.mem_valid = v;
    bus.mem_waddr = wa;
    bus.mem_wsel  = ws;
    bus.mem_alu   = alu;
    bus.mem_dm    = dm;
    bus.mem_do    = dv;
    bus.mem_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " wb_valid"},      32'(bus.wb_valid), 32'(m_we()));
    chk({tag, " wb_waddr"},      32'(bus.wb_waddr), m_we() ? 32'(m_pend.waddr) : 32'h0);
    chk({tag, " wb_wdata"},      bus.wb_wdata, m_wdata());
    chk({tag, " wb_pc"},         bus.wb_pc, m_pend.pc);
    chk({tag, " retired_count"}, bus.retired_count, m_cnt);
    chk({tag, " GRF_data_1"},    bus.GRF_data_1, m_read(bus.GRF_addr_1));
    chk({tag, " GRF_data_2"},    bus.GRF_data_2, m_read(bus.GRF_addr_2));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        vld;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [31:0] alu, dm, dov;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2, ecnt;
    logic        ewv;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // write 8 via alu, bypass then array
    tbl[0] = '{1'b1, 5'd8,  2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd0, 32'h1234_5678, 32'h0, 32'd0, 1'b1};
    tbl[1] = '{1'b0, 5'd0,  2'd0, 32'h0, 32'h0, 32'h0,          5'd8, 5'd8, 32'h1234_5678, 32'h1234_5678, 32'd1, 1'b0};
    // select coverage: dm, do, no-write
    tbl[2] = '{1'b1, 5'd9,  2'd1, 32'h1, 32'hDEAD_BEEF, 32'h2,  5'd9, 5'd10, 32'hDEAD_BEEF, RV, 32'd1, 1'b1};
    tbl[3] = '{1'b1, 5'd10, 2'd2, 32'h3, 32'h4, 32'h0040_300C,  5'd9, 5'd10, 32'hDEAD_BEEF, 32'h0040_300C, 32'd2, 1'b1};
    tbl[4] = '{1'b1, 5'd11, 2'd3, 32'h5, 32'h0, 32'h0,          5'd10, 5'd11, 32'h0040_300C, RV, 32'd3, 1'b0};
    // $0 protection
    tbl[5] = '{1'b1, 5'd0,  2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0,  5'd0, 5'd11, 32'h0, RV, 32'd4, 1'b0};
    // back-to-back writes to 4: bypass beats array
    tbl[6] = '{1'b1, 5'd4,  2'd0, 32'h1, 32'h0, 32'h0,          5'd0, 5'd0, 32'h0, 32'h0, 32'd5, 1'b1};
    tbl[7] = '{1'b1, 5'd4,  2'd0, 32'h2, 32'h0, 32'h0,          5'd4, 5'd4, 32'h2, 32'h2, 32'd6, 1'b1};
    // bubbles leave the count alone
    tbl[8] = '{1'b0, 5'd0,  2'd0, 32'h0, 32'h0, 32'h0,          5'd4, 5'd0, 32'h2, 32'h0, 32'd7, 1'b0};
    tbl[9] = '{1'b0, 5'd0,  2'd0, 32'h0, 32'h0, 32'h0,          5'd4, 5'd31, 32'h2, RV, 32'd7, 1'b0};
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] wa;
    reset = 1'b0;
    drive(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.GRF_addr_1 = 5'd0;
    bus.GRF_addr_2 = 5'd5;
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst wb_valid",      32'(bus.wb_valid), 32'h0);
    chk("rst wb_waddr",      32'(bus.wb_waddr), 32'h0);
    chk("rst wb_wdata",      bus.wb_wdata, 32'h0);
    chk("rst wb_pc",         bus.wb_pc, 32'h0);
    chk("rst retired_count", bus.retired_count, 32'h0);
    chk("rst read addr0",    bus.GRF_data_1, 32'h0);
    chk("rst read addr5",    bus.GRF_data_2, RV);
    bus.GRF_addr_2 = 5'd31;
    #1;
    chk("rst read addr31",   bus.GRF_data_2, RV);

    @(negedge clk);
    reset = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vld, tbl[i].waddr, tbl[i].wsel, tbl[i].alu, tbl[i].dm,
            tbl[i].dov, 32'h0000_3000 + 32'(i) * 4);
      bus.GRF_addr_1 = tbl[i].a1;
      bus.GRF_addr_2 = tbl[i].a2;
      tick();
      chk($sformatf("vec%0d GRF_data_1", i),    bus.GRF_data_1, tbl[i].e1);
      chk($sformatf("vec%0d GRF_data_2", i),    bus.GRF_data_2, tbl[i].e2);
      chk($sformatf("vec%0d retired_count", i), bus.retired_count, tbl[i].ecnt);
      chk($sformatf("vec%0d wb_valid", i),      32'(bus.wb_valid), 32'(tbl[i].ewv));
    end

    // async reset while WB holds a write of 0xAA to register 3
    drive(1'b1, 5'd3, 2'd0, 32'h0000_00AA, 32'h0, 32'h0, 32'h0000_4000);
    bus.GRF_addr_1 = 5'd3;
    bus.GRF_addr_2 = 5'd8;
    tick();
    chk("async pre bypass", bus.GRF_data_1, 32'h0000_00AA);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_all("async during");
    chk("async reg3 during", bus.GRF_data_1, RV);
    drive(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all("async after");
    chk("async reg3 after", bus.GRF_data_1, RV);

    // first capture after release
    drive(1'b1, 5'd3, 2'd2, 32'h1, 32'h2, 32'h0000_0077, 32'h0000_4004);
    tick();
    check_all("post-rst write");

    // counter wrap from a preloaded value
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(1'b1, 5'd12, 2'd0, 32'h0000_0C0C, 32'h0, 32'h0, 32'h0000_4008);
    tick();
    check_all("wrap1");
    drive(1'b1, 5'd13, 2'd1, 32'h0, 32'h0000_0D0D, 32'h0, 32'h0000_400C);
    tick();
    check_all("wrap2");
    chk("wrap to zero", bus.retired_count, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, wa, 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom);
      bus.GRF_addr_1 = ($urandom_range(0, 2) == 0) ? m_pend.waddr : 5'($urandom_range(0, 7));
      bus.GRF_addr_2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      tick();
      check_all($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grf_writeback.md
# grf_writeback

Write-back end of the GRF read interface used by instruction decode: holds the MEM/WB pipeline register, selects the write-back value, owns the 32×32 general register file, and answers decode's two combinational read ports with write-back bypass. Sits between the MEM stage and the register file, so decode always sees the value being retired in the same cycle.

## Interface
Parameters:
- `REG_COUNT`, 32: number of architectural registers; the address width is fixed at 5 bits.
- `RESET_VALUE`, 32'h0000_0000: value loaded into every register on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `mem_valid`  in  1  MEM stage holds a real instruction; 0 means bubble.
- `mem_waddr`  in  5  destination register.
- `mem_wsel`  in  2  write-data select: 0 = ALU result, 1 = data memory, 2 = decode DO (link / lui / compare result), 3 = no write.
- `mem_alu`  in  32  ALU result from MEM.
- `mem_dm`  in  32  data-memory read data.
- `mem_do`  in  32  DO value carried from decode.
- `mem_pc`  in  32  PC of the MEM instruction, used for trace.
- `GRF_addr_1`  in  5  read address 1, driven by decode from rs.
- `GRF_addr_2`  in  5  read address 2, driven by decode from rt or 0.
- `GRF_data_1`  out  32  read data 1, combinational.
- `GRF_data_2`  out  32  read data 2, combinational.
- `wb_valid`  out  1  WB register holds an instruction that writes.
- `wb_waddr`  out  5  WB destination, for the hazard / forwarding unit.
- `wb_wdata`  out  32  selected WB data.
- `wb_pc`  out  32  PC of the WB instruction.
- `retired_count`  out  32  number of valid instructions that have passed WB.

## Operation
- WB register: on each rising edge it captures `mem_valid`, `mem_waddr`, `mem_wsel`, `mem_alu`, `mem_dm`, `mem_do`, `mem_pc`. There is no stall input; the register updates every cycle.
- Write data (`wb_wdata`):
  - wsel 0 → alu
  - wsel 1 → dm
  - wsel 2 → do
  - wsel 3 → 0
- Write enable: `we = wb_valid_int && wsel != 3 && waddr != 0`.
- `wb_valid` is the output form of `we`. `wb_waddr` is forced to 0 when `we` = 0.
- Register file: on the rising edge, if `we` is set, `reg[waddr] <= wb_wdata`.
- Register 0 always reads as 0 and is never written.
- Read port k: `GRF_data_k` = 0 if `GRF_addr_k` == 0. Otherwise it is `wb_wdata` if `we` is set and `GRF_addr_k == wb_waddr` (bypass). Otherwise it is `reg[GRF_addr_k]`.
- Both ports may read the same address. Both bypass independently.
- `retired_count` increments on each rising edge where the internal WB-valid bit (before `we` masking) is 1. This includes wsel 3 and waddr 0 cases. It wraps from 32'hFFFF_FFFF to 0.
- Reset (`reset` = 0, at any time, including mid-stream):
  - all registers go to `RESET_VALUE`, with register 0 still reading 0;
  - the WB valid bit clears, and the other WB fields go to 0;
  - `retired_count` goes to 0.
  - An in-flight write is discarded.
  - Outputs during reset: `wb_valid` 0, `wb_waddr` 0, `wb_wdata` 0, `wb_pc` 0, `retired_count` 0. Read data reflects `RESET_VALUE`, or 0 for address 0.

## Timing
- MEM inputs sampled at edge N appear on the `wb_*` outputs after edge N.
- The register file is updated at edge N+1.
- Bypass makes the value visible on the read ports during cycle N→N+1, i.e. zero extra latency for decode.
- Read ports are purely combinational from `GRF_addr_*` and state. There is no read latency.
- When reset deasserts, the first capture happens at the next rising edge.
- Back-to-back writes to the same register: the later write wins. Its bypass overrides the array contents for its WB cycle.

## Test plan
- Reset then read: assert `reset`=0, release. Reading addresses 0, 5 and 31 returns 0. `retired_count` is 0 and `wb_valid` is 0.
- Write then read: MEM presents valid, waddr 8, wsel 0, alu 32'h1234_5678. After edge 1, `GRF_data_1` at address 8 returns 32'h1234_5678 through bypass. After edge 2 it still returns it, now from the array. `retired_count` is 1.
- Select coverage: three consecutive writes to 9, 10 and 11 with wsel 1 (dm 32'hDEAD_BEEF), wsel 2 (do 32'h0040_300C), and wsel 3 (alu 32'h5). Registers 9 and 10 hold those values. Register 11 is unchanged. `retired_count` is 3.
- $0 protection: valid write to waddr 0 with alu 32'hFFFF_FFFF. Read of address 0 returns 0 in the WB cycle and afterwards. `wb_valid` is 0. `retired_count` increments.
- Bypass priority: register 4 = 32'h1, then a write to 4 with 32'h2. In the WB cycle, both read ports at address 4 return 32'h2. Bubbles (`mem_valid`=0) do not change `retired_count`.
- Async reset mid-stream: pull `reset` low between edges while WB holds a write of 32'hAA to register 3. Outputs clear immediately. Register 3 reads `RESET_VALUE` after release. Preload `retired_count` near 32'hFFFF_FFFF in a separate run and confirm it wraps to 0.
